uart_tx_fifo_reader: RTL and testbench
======================================

UART_TX_FIFO_READER -- requirements
Module: uart_tx_fifo_reader

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, giving the data width, matching the FIFO read port.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, giving rclk cycles per serial bit; legal values are 2 or more.
REQ-003 The block SHALL have parameter PARITY_EN, default 0; a value of 1 inserts an even-parity bit after the data bits.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low: port rclk, input, 1 bit, the only clock, rising edge.
REQ-005 Port rrst_n SHALL be an input, 1 bit, synchronous active-low reset sampled on the rclk rising edge.
REQ-006 Port rdata SHALL be an input, DSIZE bits, FIFO read data, valid combinationally whenever rempty=0.
REQ-007 Port rempty SHALL be an input, 1 bit, FIFO empty flag.
REQ-008 Port rinc SHALL be an output, 1 bit, FIFO pop strobe; the FIFO advances one word on each rclk edge where rinc=1.
REQ-009 Port txd SHALL be an output, 1 bit, registered serial line with idle level 1.
REQ-010 Port busy SHALL be an output, 1 bit, high while a frame is on the line.

Function
REQ-011 The block SHALL use a state machine with states IDLE, START, DATA, PARITY and STOP; PARITY is entered only when PARITY_EN=1.
REQ-012 rinc SHALL be combinational: rinc = rrst_n & ~rempty & (state==IDLE | (state==STOP & baud_cnt==CLKS_PER_BIT-1)).
REQ-013 On each edge where rinc=1, the block SHALL load rdata into the shift register, compute its parity, clear baud_cnt and bit_cnt, and enter START.
REQ-014 In IDLE with rempty=1, rinc SHALL be 0, txd SHALL be 1, and the block SHALL stay in IDLE.
REQ-015 txd SHALL be 0 in START, shift_reg[0] in DATA (LSB first), the parity bit (XOR of the data) in PARITY, and 1 in STOP and IDLE.
REQ-016 Each of START, DATA, PARITY and STOP SHALL hold each bit for exactly CLKS_PER_BIT cycles; baud_cnt counts 0..CLKS_PER_BIT-1 and then wraps to 0.
REQ-017 In DATA, on each baud wrap the block SHALL shift the register right and increment bit_cnt; after DSIZE bits it enters PARITY (PARITY_EN=1) or STOP.
REQ-018 The first cycle with txd=0 SHALL be the cycle after the pop edge, giving a pop-to-start latency of 1 cycle.
REQ-019 The frame length SHALL be (DSIZE+2+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-020 At the last STOP cycle with rempty=0, the block SHALL pop and go directly to START, so back-to-back frames have no idle gap.
REQ-021 At the last STOP cycle with rempty=1, the block SHALL go to IDLE.
REQ-022 A word that arrives while a frame is in progress SHALL NOT be popped until that last STOP cycle.
REQ-023 rempty rising mid-frame SHALL NOT affect the current frame.
REQ-024 The block SHALL issue at most one rinc per frame and SHALL never assert rinc while rempty=1.
REQ-025 busy SHALL equal (state != IDLE), registered.

Reset
REQ-026 While rrst_n=0 at a clock edge, the block SHALL set state=IDLE, txd=1, busy=0, baud_cnt=0, bit_cnt=0 and shift_reg=0; rinc SHALL be 0.
REQ-027 A reset mid-frame SHALL abort the frame: txd returns to 1 on that edge, and the popped word is discarded without re-reading.
REQ-028 After rrst_n deasserts with rempty=0, the first pop SHALL occur in the first cycle with rrst_n=1.

Verification
REQ-029 Reset, rempty=1 for 100 cycles -> txd=1, busy=0, rinc=0 throughout.
REQ-030 CLKS_PER_BIT=4, PARITY_EN=0, FIFO holds 0xA5 -> one rinc pulse, then txd = 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles wide, frame 40 cycles, then IDLE.
REQ-031 PARITY_EN=1, byte 0x07 -> parity bit 1 after bit7, frame 44 cycles at CLKS_PER_BIT=4.
REQ-032 FIFO holds 0x55, 0x00 and 0xFF -> three rinc pulses spaced exactly 40 cycles apart, no idle cycle between frames, busy high for 120 cycles.
REQ-033 rrst_n pulsed low for 1 cycle at cycle 13 of a frame -> txd=1 and busy=0 after that edge; the next word is popped in the first cycle after rrst_n returns high.
REQ-034 rempty toggles to 0 mid-frame -> no rinc until the last STOP cycle; a scoreboard compares the serial-decoded bytes against the FIFO write order.

Source files
------------

// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader
// Pops words from a FIFO read port and sends each one as an 8N1-style UART
// frame (start, DSIZE data bits LSB first, optional even parity, stop).
// Back-to-back words go out with no idle gap between frames.

module uart_tx_fifo_reader #(
    parameter int DSIZE        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    output logic             txd,
    output logic             busy
);

    // CLKS_PER_BIT >= 2, so the baud counter is always at least one bit wide.
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (DSIZE > 1) ? $clog2(DSIZE) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DSIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DSIZE-1:0]   shift_reg;
    logic [DSIZE-1:0]   shift_next;
    logic               parity_bit;
    logic               baud_wrap;

    assign baud_wrap  = (baud_cnt == BAUD_LAST);
    assign shift_next = shift_reg >> 1;

    // Pop strobe: take a word when idle, or on the final stop-bit cycle so
    // the next frame starts without a gap. Gated by reset and FIFO empty.
    assign rinc = rrst_n & ~rempty &
                  ((state == IDLE) | ((state == STOP) & baud_wrap));

    // Frame sequencer: state, bit timing, shift register and registered line outputs.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            // NOTE: non-blocking assignments keep every register in this block
            // sampling pre-edge values, so ordering of statements does not matter.
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            // NOTE: the shift register is plain flops (not a memory), so it is
            // cleared with the rest to keep post-reset state fully defined.
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            txd        <= 1'b1;
            busy       <= 1'b0;
        end else if (rinc) begin
            // Pop edge: capture the word and put the start bit on the line next cycle.
            state      <= START;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= rdata;
            parity_bit <= ^rdata;
            txd        <= 1'b0;
            busy       <= 1'b1;
        end else begin
            if (state != IDLE) begin
                baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
            end

            if (baud_wrap) begin
                case (state)
                    START: begin
                        state <= DATA;
                        txd   <= shift_reg[0];
                    end
                    DATA: begin
                        shift_reg <= shift_next;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN) begin
                                state <= PARITY;
                                txd   <= parity_bit;
                            end else begin
                                state <= STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            txd     <= shift_next[0];
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                    STOP: begin
                        // Reached only when nothing is waiting; otherwise rinc wins above.
                        state <= IDLE;
                        txd   <= 1'b1;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        txd   <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb_uart_tx_fifo_reader
// Directed bench: two instances at CLKS_PER_BIT=4, one without and one with
// parity, each fed from its own queue-backed FIFO model.

module tb_uart_tx_fifo_reader;

    logic       clk;
    logic       rrst_n;
    logic [7:0] rdata0, rdata1;
    logic       rempty0, rempty1;
    logic       rinc0, rinc1;
    logic       txd0, txd1;
    logic       busy0, busy1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] sb[$];

    int cmp_cnt;
    int err_cnt;
    int viol0, viol1;
    int pops0, pops1;

    uart_tx_fifo_reader #(.DSIZE(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut0 (
        .rclk   (clk),
        .rrst_n (rrst_n),
        .rdata  (rdata0),
        .rempty (rempty0),
        .rinc   (rinc0),
        .txd    (txd0),
        .busy   (busy0)
    );

    uart_tx_fifo_reader #(.DSIZE(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
        .rclk   (clk),
        .rrst_n (rrst_n),
        .rdata  (rdata1),
        .rempty (rempty1),
        .rinc   (rinc1),
        .txd    (txd1),
        .busy   (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model outputs follow the head of each queue.
    task automatic drive();
        rempty0 = (q0.size() == 0);
        rdata0  = rempty0 ? 8'h00 : q0[0];
        rempty1 = (q1.size() == 0);
        rdata1  = rempty1 ? 8'h00 : q1[0];
    endtask

    task automatic push(input int sel, input logic [7:0] val);
        if (sel == 0) q0.push_back(val);
        else          q1.push_back(val);
        drive();
    endtask

    // One clock: sample rinc before the edge, pop on the edge, refresh
    // the FIFO outputs, then leave time for outputs to settle.
    task automatic tick();
        logic r0, r1;
        logic [7:0] tmp;
        #1;
        r0 = rinc0;
        r1 = rinc1;
        if (r0 === 1'b1 && rempty0) viol0++;
        if (r1 === 1'b1 && rempty1) viol1++;
        @(posedge clk);
        if (r0 === 1'b1 && q0.size() > 0) begin tmp = q0.pop_front(); pops0++; end
        if (r1 === 1'b1 && q1.size() > 0) begin tmp = q1.pop_front(); pops1++; end
        #1;
        drive();
        #1;
    endtask

    // Walk one frame cycle by cycle against a hand-written bit vector
    // (bit 0 goes out first); rinc is expected only on the last cycle.
    task automatic frame(input int sel, input logic [10:0] bits, input int nbits,
                         input logic last_pop, input string tag);
        for (int k = 0; k < nbits * 4; k++) begin
            check($sformatf("%s txd c%0d", tag, k), (sel == 0) ? txd0 : txd1, bits[k / 4]);
            check($sformatf("%s busy c%0d", tag, k), (sel == 0) ? busy0 : busy1, 1'b1);
            check($sformatf("%s rinc c%0d", tag, k), (sel == 0) ? rinc0 : rinc1,
                  (k == nbits * 4 - 1) ? last_pop : 1'b0);
            tick();
        end
    endtask

    // Serial receiver on dut0: samples each bit mid-cell and returns the byte.
    task automatic rx_frame(input int push_at, input logic [7:0] push_val,
                            input logic last_pop, input string tag,
                            output logic [7:0] got);
        got = 8'h00;
        for (int k = 0; k < 40; k++) begin
            if (k == push_at) begin
                push(0, push_val);
                sb.push_back(push_val);
                #1;
            end
            if (k % 4 == 2) begin
                if (k / 4 == 0)      check($sformatf("%s start", tag), txd0, 1'b0);
                else if (k / 4 == 9) check($sformatf("%s stop", tag), txd0, 1'b1);
                else                 got[k / 4 - 1] = txd0;
            end
            check($sformatf("%s rinc c%0d", tag, k), rinc0, (k == 39) ? last_pop : 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] exp_b;
        cmp_cnt = 0;
        err_cnt = 0;
        viol0 = 0; viol1 = 0;
        pops0 = 0; pops1 = 0;
        rrst_n = 1'b0;
        drive();

        // Reset state.
        repeat (3) tick();
        check("rst txd0", txd0, 1'b1);
        check("rst busy0", busy0, 1'b0);
        check("rst rinc0", rinc0, 1'b0);
        check("rst txd1", txd1, 1'b1);
        check("rst busy1", busy1, 1'b0);
        check("rst rinc1", rinc1, 1'b0);

        // Empty FIFO for 100 cycles: line stays idle.
        rrst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            check($sformatf("idle txd c%0d", k), txd0, 1'b1);
            check($sformatf("idle busy c%0d", k), busy0, 1'b0);
            check($sformatf("idle rinc c%0d", k), rinc0, 1'b0);
            tick();
        end

        // Single word 0xA5: 0,1,0,1,0,0,1,0,1,1.
        push(0, 8'hA5);
        #1;
        check("a5 pop", rinc0, 1'b1);
        tick();
        frame(0, 11'b0_1_1010_0101_0, 10, 1'b0, "a5");
        check("a5 end txd", txd0, 1'b1);
        check("a5 end busy", busy0, 1'b0);
        check("a5 end rinc", rinc0, 1'b0);

        // Parity instance, 0x07: three ones, even parity bit = 1, 44 cycles.
        push(1, 8'h07);
        #1;
        check("p07 pop", rinc1, 1'b1);
        tick();
        frame(1, 11'b1_1_0000_0111_0, 11, 1'b0, "p07");
        check("p07 end txd", txd1, 1'b1);
        check("p07 end busy", busy1, 1'b0);

        // Three words back to back: pops 40 cycles apart, busy for 120 cycles.
        push(0, 8'h55);
        push(0, 8'h00);
        push(0, 8'hFF);
        #1;
        check("b2b pop", rinc0, 1'b1);
        tick();
        frame(0, 11'b0_1_0101_0101_0, 10, 1'b1, "b55");
        frame(0, 11'b0_1_0000_0000_0, 10, 1'b1, "b00");
        frame(0, 11'b0_1_1111_1111_0, 10, 1'b0, "bff");
        check("b2b end busy", busy0, 1'b0);
        check("b2b end txd", txd0, 1'b1);

        // One-cycle reset at cycle 13 of a 0x3C frame; 0x81 follows immediately.
        push(0, 8'h3C);
        push(0, 8'h81);
        tick();
        repeat (12) tick();
        check("rst mid c12 txd", txd0, 1'b1);
        tick();
        rrst_n = 1'b0;
        #1;
        check("rst mid rinc", rinc0, 1'b0);
        tick();
        check("rst mid txd", txd0, 1'b1);
        check("rst mid busy", busy0, 1'b0);
        rrst_n = 1'b1;
        #1;
        check("rst rel pop", rinc0, 1'b1);
        tick();
        frame(0, 11'b0_1_1000_0001_0, 10, 1'b0, "r81");

        // Word arrives mid-frame: popped only on the last stop cycle.
        push(0, 8'h3A);
        sb.push_back(8'h3A);
        tick();
        rx_frame(10, 8'hC4, 1'b1, "sb0", got);
        exp_b = sb.pop_front();
        check("sb0 byte", got, exp_b);
        rx_frame(-1, 8'h00, 1'b0, "sb1", got);
        exp_b = sb.pop_front();
        check("sb1 byte", got, exp_b);
        check("sb end busy", busy0, 1'b0);
        check("sb end txd", txd0, 1'b1);

        // Global invariants.
        check("rinc0 while empty", viol0, 0);
        check("rinc1 while empty", viol1, 0);
        check("pops0 total", pops0, 8);
        check("pops1 total", pops1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
